multi_tap_recorder: RTL
=======================

Name: multi_tap_recorder

Overview:
- Parametrised successor to the single-channel audio recorder: records signed PCM samples into on-chip memory, then plays them back with a configurable multi-tap echo mix and an optional loop mode.
- Sits between the audio sample source (ADC/mic path, one strobe per sample) and the output/PWM path.
- Replaces hard-coded delays, width and depth with parameters and run-time tap registers.
- Adds saturation, overrun detection and loop playback.

Parameters:
- WIDTH, 8, sample width in bits (signed, two's complement).
- DEPTH, 16384, sample capacity; need not be a power of two.
- NUM_TAPS, 2, number of echo taps, 1..4.
- ADDR_W, $clog2(DEPTH), address and delay width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- audio_in  input  WIDTH  signed input sample.
- audio_valid_in  input  1  one-cycle sample strobe; at least NUM_TAPS+4 cycles apart.
- record_in  input  1  level; high = record.
- play_in  input  1  level; high = play.
- loop_in  input  1  wrap playback at end of recording.
- tap_delay_in  input  NUM_TAPS*ADDR_W  tap k delay in samples, in bits [k*ADDR_W +: ADDR_W]; 0 disables tap k.
- tap_shift_in  input  NUM_TAPS*3  tap k attenuation as an arithmetic right shift of 0..7.
- audio_out  output  WIDTH  signed mixed output sample.
- audio_valid_out  output  1  one-cycle strobe, one per accepted play strobe.
- length_out  output  ADDR_W+1  recorded length in samples.
- full_out  output  1  memory filled during the current recording.
- overrun_out  output  1  one-cycle pulse: strobe arrived while the sequencer was busy.
- finish_out  output  1  one-cycle pulse at end of recording or end of non-loop playback.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; wr_ptr = rd_ptr = 0; length = 0. Memory contents are not cleared and are unreachable while length = 0.
- Memory: single array, one write port, one synchronous read port, 1-cycle read latency. A read of the address being written in the same cycle returns the old data.
- FSM states: IDLE, RECORD, PLAY_FETCH, PLAY_MIX.
  - IDLE -> RECORD when record_in = 1. Record has priority over play.
  - IDLE -> PLAY_FETCH on audio_valid_in when play_in = 1 and length > 0.
- RECORD:
  - Entry sets wr_ptr = 0 and clears full_out.
  - Each audio_valid_in writes audio_in at wr_ptr, then wr_ptr += 1.
  - When wr_ptr reaches DEPTH: further strobes are ignored and full_out = 1.
  - record_in falling: length_out <= wr_ptr, one-cycle finish_out pulse, go to IDLE, rd_ptr <= 0.
- PLAY_FETCH:
  - The strobe cycle issues a read of rd_ptr (the dry sample).
  - The next NUM_TAPS cycles issue a read of tap k at rd_ptr - delay_k.
  - If delay_k = 0, or delay_k > rd_ptr with loop_in = 0, tap k contributes 0.
  - If delay_k > rd_ptr with loop_in = 1, the address wraps to rd_ptr + length - delay_k.
  - If delay_k >= length, tap k contributes 0.
- PLAY_MIX:
  - Accumulator width is WIDTH+3.
  - sum = dry + Σ (tap_k >>> shift_k), using arithmetic shifts.
  - The sum saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Output timing: audio_out is registered, and audio_valid_out pulses exactly NUM_TAPS+3 cycles after the accepted strobe. audio_out holds its value between strobes.
- Pointer advance after each output: rd_ptr += 1. When rd_ptr reaches length:
  - loop_in = 1: rd_ptr <= 0 and playback continues.
  - loop_in = 0: finish_out pulse, rd_ptr <= 0, go to IDLE.
- play_in falling: the sample in flight completes, then go to IDLE with rd_ptr <= 0 and no finish_out.
- A strobe arriving during PLAY_FETCH/PLAY_MIX is dropped and overrun_out pulses for one cycle.
- record_in rising during play: the in-flight sample completes, then go to RECORD.
- Tap delays and shifts are sampled at each accepted strobe. Changing them mid-sample has no effect until the next sample.
- Reset asserted mid-operation: immediate return to IDLE, and any pending audio_valid_out or finish_out is suppressed.

Test Plan:
- Record 5 samples (10, 20, 30, 40, 50), drop record_in:
  - finish_out pulses once, length_out = 5.
  - Play with NUM_TAPS = 2, both delays 0: outputs 10, 20, 30, 40, 50, each valid NUM_TAPS+3 = 5 cycles after its strobe, then finish_out.
- Echo mix, same recording, tap0 delay = 2, shift = 1, loop_in = 0:
  - Outputs 10, 20, 35, 50, 65.
  - Set loop_in = 1: the first sample becomes 10 + (40 >>> 1) = 30.
- Saturation, WIDTH = 8: record 100, 100; tap0 delay 1, shift 0 → outputs 100, 127.
  - Record -100, -100 → outputs -100, -128.
- Capacity: DEPTH = 16, record 20 strobes → full_out = 1, length_out = 16, strobes 17-20 not written.
  - Loop playback of 40 strobes yields the 16-sample sequence 2.5 times with no finish_out.
- Overrun: issue two play strobes 2 cycles apart → second strobe dropped, overrun_out pulses once, exactly one audio_valid_out.
- Reset mid-playback on cycle 2 of PLAY_FETCH: all outputs 0 immediately, no audio_valid_out follows, length_out = 0, a subsequent play_in produces no output.

Source files
------------

// File: rtl/multi_tap_recorder.sv
// multi_tap_recorder: records signed PCM into on-chip memory and plays it back
// mixed with up to four delayed, attenuated echo taps, with optional looping.
module multi_tap_recorder #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16384,
   parameter int NUM_TAPS = 2,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic signed [WIDTH-1:0]    audio_in,
   input  logic                       audio_valid_in,
   input  logic                       record_in,
   input  logic                       play_in,
   input  logic                       loop_in,
   input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay_in,
   input  logic [NUM_TAPS*3-1:0]      tap_shift_in,
   output logic signed [WIDTH-1:0]    audio_out,
   output logic                       audio_valid_out,
   output logic [ADDR_W:0]            length_out,
   output logic                       full_out,
   output logic                       overrun_out,
   output logic                       finish_out
);
   localparam int ACC_W  = WIDTH + 3;
   localparam int PW     = ADDR_W + 2;   // holds rd_ptr + length without overflow
   localparam int STEP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (WIDTH-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, RECORD, PLAY_FETCH, PLAY_MIX} state_t;

   state_t                          state_q, state_d;
   logic [ADDR_W:0]                 wr_ptr, rd_ptr, rd_next, wr_next;
   logic [STEP_W-1:0]               step_q;
   logic [NUM_TAPS-1:0][ADDR_W-1:0] delay_q;
   logic [NUM_TAPS-1:0][2:0]        shift_q;
   logic [NUM_TAPS-1:0][ADDR_W-1:0] tap_addr;
   logic [NUM_TAPS-1:0]             tap_ok;
   logic [ADDR_W-1:0]               rd_addr;
   logic signed [WIDTH-1:0]         rd_data;
   logic                            rd_dry_q, rd_ok_q;
   logic [2:0]                      rd_sh_q;
   logic signed [ACC_W-1:0]         acc_q, rd_ext, contrib;
   logic signed [WIDTH-1:0]         sat;
   logic                            accept, rec_start, rec_end, wr_en, busy;
   logic                            last_fetch, mix_done;

   logic [WIDTH-1:0] mem [DEPTH];

   assign accept     = (state_q == IDLE) && !record_in && audio_valid_in && play_in &&
                       (length_out != '0);
   assign rec_start  = (state_q == IDLE) && record_in;
   assign rec_end    = (state_q == RECORD) && !record_in;
   assign wr_en      = (state_q == RECORD) && record_in && audio_valid_in && (wr_ptr < DEPTH_P);
   assign busy       = (state_q == PLAY_FETCH) || (state_q == PLAY_MIX);
   assign last_fetch = (step_q == STEP_W'(NUM_TAPS-1));
   assign mix_done   = (state_q == PLAY_MIX) && (step_q == STEP_W'(1));
   assign rd_next    = rd_ptr + (ADDR_W+1)'(1);
   assign wr_next    = wr_ptr + (ADDR_W+1)'(1);

   // Per-tap read address and enable; a tap past the start either wraps (loop) or is muted.
   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      logic [PW-1:0] d, p, len;
      assign d           = PW'(delay_q[k]);
      assign p           = PW'(rd_ptr);
      assign len         = PW'(length_out);
      assign tap_ok[k]   = (d != '0) && (d < len) && ((d <= p) || loop_in);
      assign tap_addr[k] = (d <= p) ? ADDR_W'(p - d) : ADDR_W'(p + len - d);
   end

   // Read address: dry sample on the accepted strobe, then one tap per fetch cycle.
   always_comb begin
      rd_addr = ADDR_W'(rd_ptr);
      if (state_q == PLAY_FETCH) rd_addr = tap_addr[step_q];
   end

   // Sample memory: one write port, registered read (old data on same-address collision).
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= audio_in;
      rd_data <= mem[rd_addr];
   end

   assign rd_ext  = ACC_W'(rd_data);
   assign contrib = rd_ok_q ? (rd_ext >>> rd_sh_q) : '0;

   // Clamp the accumulator into the signed sample range.
   always_comb begin
      sat = acc_q[WIDTH-1:0];
      if (acc_q > SAT_HI)      sat = SAT_HI[WIDTH-1:0];
      else if (acc_q < SAT_LO) sat = SAT_LO[WIDTH-1:0];
   end

   // State register.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; record wins over play when idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (record_in) state_d = RECORD;
                     else if (accept) state_d = PLAY_FETCH;
         RECORD:     if (!record_in) state_d = IDLE;
         PLAY_FETCH: if (last_fetch) state_d = PLAY_MIX;
         PLAY_MIX:   if (mix_done) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Step counter, read tags travelling with the memory latency, and the mix accumulator.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         step_q   <= '0;
         rd_dry_q <= 1'b0;
         rd_ok_q  <= 1'b0;
         rd_sh_q  <= '0;
         acc_q    <= '0;
      end else begin
         if (state_q == PLAY_FETCH)    step_q <= last_fetch ? '0 : step_q + STEP_W'(1);
         else if (state_q == PLAY_MIX) step_q <= mix_done ? '0 : step_q + STEP_W'(1);
         else                          step_q <= '0;
         rd_dry_q <= accept;
         rd_ok_q  <= (state_q == PLAY_FETCH) && tap_ok[step_q];
         rd_sh_q  <= shift_q[step_q];
         if (rd_dry_q) acc_q <= rd_ext;
         else if ((state_q == PLAY_FETCH) || ((state_q == PLAY_MIX) && (step_q == '0)))
            acc_q <= acc_q + contrib;
      end
   end

   // Pointers, length, status pulses and the registered output sample.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         length_out      <= '0;
         full_out        <= 1'b0;
         finish_out      <= 1'b0;
         overrun_out     <= 1'b0;
         audio_out       <= '0;
         audio_valid_out <= 1'b0;
         delay_q         <= '0;
         shift_q         <= '0;
      end else begin
         finish_out      <= 1'b0;
         audio_valid_out <= 1'b0;
         overrun_out     <= audio_valid_in && busy;
         if (rec_start) begin
            wr_ptr   <= '0;
            full_out <= 1'b0;
         end
         if (wr_en) begin
            wr_ptr <= wr_next;
            if (wr_next == DEPTH_P) full_out <= 1'b1;
         end
         if (rec_end) begin
            length_out <= wr_ptr;
            finish_out <= 1'b1;
            rd_ptr     <= '0;
         end
         if ((state_q == IDLE) && !play_in) rd_ptr <= '0;
         if (accept) begin
            delay_q <= tap_delay_in;
            shift_q <= tap_shift_in;
         end
         if (mix_done) begin
            audio_out       <= sat;
            audio_valid_out <= 1'b1;
            if (!play_in) rd_ptr <= '0;
            else if (rd_next >= length_out) begin
               rd_ptr <= '0;
               if (!loop_in) finish_out <= 1'b1;
            end else rd_ptr <= rd_next;
         end
      end
   end
endmodule
